gmii_ptp_rx_parser: RTL and testbench

- Passive monitor on the GMII receive path, beside the gig_eth_ptpv2_lite_apb receive port, on the same gmii_rx_clk domain.
- Detects the SFD of every frame and emits a one-cycle strobe for RX timestamp capture.
- Parses PTPv2 frames carried either over raw Ethernet (EtherType 0x88F7) or over IPv4/UDP (ports 319/320).
- At end of frame, reports messageType, sequenceId and domainNumber so firmware can match timestamps to messages.

---
 rtl/gmii_ptp_rx_parser.sv | 192 +++++++++++++++++++
 tb/tb_gmii_ptp_rx_parser.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_ptp_rx_parser.sv
// gmii_ptp_rx_parser
// Passive monitor on the GMII receive path. It flags the SFD of every frame
// so the RX timestamp can be captured. It also recognises PTPv2 messages
// carried over raw Ethernet (EtherType 0x88F7) or over IPv4/UDP (ports
// 319/320). When such a frame ends, it reports messageType, domainNumber and
// sequenceId so firmware can pair timestamps with messages.
//
// Ports
//   gmii_rx_clk   receive clock (125 MHz); everything here runs on it
//   reset         synchronous, active-high
//   gmii_rxd      receive data byte
//   gmii_rxdv     receive data valid
//   gmii_rxer     receive error
//   sfd_pulse     1-cycle strobe, SFD received
//   ptp_valid     1-cycle strobe, well-formed PTP message ended
//   ptp_udp       1 = message came over UDP, 0 = Layer-2
//   ptp_event     1 when ptp_msg_type < 8
//   ptp_msg_type  PTP messageType nibble
//   ptp_domain    PTP domainNumber
//   ptp_seq_id    PTP sequenceId
//   frame_error   1-cycle strobe: rxer, bad preamble or truncated PTP frame
//
// All outputs are registered. The data outputs hold until the next
// ptp_valid.
module gmii_ptp_rx_parser #(
  parameter logic PTPV2_L2  = 1'b1,
  parameter logic PTPV2_UDP = 1'b1,
  parameter int   CNT_WIDTH = 8
) (
  input  logic        gmii_rx_clk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  output logic        sfd_pulse,
  output logic        ptp_valid,
  output logic        ptp_udp,
  output logic        ptp_event,
  output logic [3:0]  ptp_msg_type,
  output logic [7:0]  ptp_domain,
  output logic [15:0] ptp_seq_id,
  output logic        frame_error
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_BODY, S_DROP} state_t;

  // Offset of the last byte each encapsulation needs (the seqId low byte).
  localparam logic [CNT_WIDTH-1:0] L2_LAST  = CNT_WIDTH'(45);
  localparam logic [CNT_WIDTH-1:0] UDP_LAST = CNT_WIDTH'(73);

  state_t               r_state;
  logic                 r_armed;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_l2_ok;
  logic                 r_udp_ok;
  logic [3:0]           r_l2_type;
  logic [7:0]           r_l2_dom;
  logic [15:0]          r_l2_seq;
  logic [3:0]           r_udp_type;
  logic [7:0]           r_udp_dom;
  logic [15:0]          r_udp_seq;

  logic w_cnt_sat;
  logic w_l2_bad;
  logic w_udp_bad;

  assign w_cnt_sat = (r_cnt == '1);

  // Per-byte header checks for the byte now being received. A saturated
  // counter never equals a checked offset, so very long frames are unaffected.
  always_comb begin
    w_l2_bad  = 1'b0;
    w_udp_bad = 1'b0;
    case (int'(r_cnt))
      12: begin
        w_l2_bad  = (gmii_rxd != 8'h88);
        w_udp_bad = (gmii_rxd != 8'h08);
      end
      13: begin
        w_l2_bad  = (gmii_rxd != 8'hF7);
        w_udp_bad = (gmii_rxd != 8'h00);
      end
      14: w_udp_bad = (gmii_rxd != 8'h45);        // IPv4, IHL=5 only
      15: w_l2_bad  = (gmii_rxd[3:0] != 4'h2);    // versionPTP
      23: w_udp_bad = (gmii_rxd != 8'h11);        // protocol = UDP
      36: w_udp_bad = (gmii_rxd != 8'h01);        // dst port high byte
      37: w_udp_bad = (gmii_rxd != 8'h3F) && (gmii_rxd != 8'h40); // 319/320
      43: w_udp_bad = (gmii_rxd[3:0] != 4'h2);    // versionPTP
      default: ;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b0;
      r_cnt        <= '0;
      r_l2_ok      <= 1'b0;
      r_udp_ok     <= 1'b0;
      r_l2_type    <= '0;
      r_l2_dom     <= '0;
      r_l2_seq     <= '0;
      r_udp_type   <= '0;
      r_udp_dom    <= '0;
      r_udp_seq    <= '0;
      sfd_pulse    <= 1'b0;
      ptp_valid    <= 1'b0;
      ptp_udp      <= 1'b0;
      ptp_event    <= 1'b0;
      ptp_msg_type <= '0;
      ptp_domain   <= '0;
      ptp_seq_id   <= '0;
      frame_error  <= 1'b0;
    end else begin
      sfd_pulse   <= 1'b0;
      ptp_valid   <= 1'b0;
      frame_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // After reset, a frame may already be in flight. Ignore it until
          // the line goes quiet.
          if (!r_armed) begin
            if (!gmii_rxdv) r_armed <= 1'b1;
          end else if (gmii_rxdv) begin
            r_state <= (gmii_rxd == 8'h55) ? S_PRE : S_DROP;
          end
        end
        S_PRE: begin
          if (!gmii_rxdv) begin
            r_state <= S_IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            r_state   <= S_BODY;
            sfd_pulse <= 1'b1;
            r_cnt     <= '0;
            r_l2_ok   <= PTPV2_L2;
            r_udp_ok  <= PTPV2_UDP;
          end else if (gmii_rxd != 8'h55) begin
            r_state     <= S_DROP;
            frame_error <= 1'b1;
          end
        end
        S_BODY: begin
          if (gmii_rxer) begin
            // Error wins even when it coincides with the end of the frame.
            frame_error <= 1'b1;
            r_state     <= gmii_rxdv ? S_DROP : S_IDLE;
          end else if (!gmii_rxdv) begin
            r_state <= S_IDLE;
            if (r_l2_ok && (r_cnt > L2_LAST)) begin
              ptp_valid    <= 1'b1;
              ptp_udp      <= 1'b0;
              ptp_event    <= ~r_l2_type[3];
              ptp_msg_type <= r_l2_type;
              ptp_domain   <= r_l2_dom;
              ptp_seq_id   <= r_l2_seq;
            end else if (r_udp_ok && (r_cnt > UDP_LAST)) begin
              ptp_valid    <= 1'b1;
              ptp_udp      <= 1'b1;
              ptp_event    <= ~r_udp_type[3];
              ptp_msg_type <= r_udp_type;
              ptp_domain   <= r_udp_dom;
              ptp_seq_id   <= r_udp_seq;
            end else if (r_l2_ok || r_udp_ok) begin
              // Header still matched, but the frame ended before the seqId.
              frame_error <= 1'b1;
            end
          end else begin
            if (w_l2_bad)   r_l2_ok  <= 1'b0;
            if (w_udp_bad)  r_udp_ok <= 1'b0;
            if (!w_cnt_sat) r_cnt    <= r_cnt + 1'b1;
            case (int'(r_cnt))
              14: r_l2_type        <= gmii_rxd[3:0];
              18: r_l2_dom         <= gmii_rxd;
              42: r_udp_type       <= gmii_rxd[3:0];
              44: r_l2_seq[15:8]   <= gmii_rxd;
              45: r_l2_seq[7:0]    <= gmii_rxd;
              46: r_udp_dom        <= gmii_rxd;
              72: r_udp_seq[15:8]  <= gmii_rxd;
              73: r_udp_seq[7:0]   <= gmii_rxd;
              default: ;
            endcase
          end
        end
        S_DROP: begin
          if (!gmii_rxdv) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_ptp_rx_parser.sv
// Directed testbench for gmii_ptp_rx_parser. Inputs change on the falling
// edge. Outputs are sampled 1 ns after the rising edge.
module tb_gmii_ptp_rx_parser;

  logic        gmii_rx_clk = 1'b0;
  logic        reset       = 1'b1;
  logic [7:0]  gmii_rxd    = 8'h00;
  logic        gmii_rxdv   = 1'b0;
  logic        gmii_rxer   = 1'b0;
  logic        sfd_pulse;
  logic        ptp_valid;
  logic        ptp_udp;
  logic        ptp_event;
  logic [3:0]  ptp_msg_type;
  logic [7:0]  ptp_domain;
  logic [15:0] ptp_seq_id;
  logic        frame_error;

  gmii_ptp_rx_parser dut (
    .gmii_rx_clk (gmii_rx_clk),
    .reset       (reset),
    .gmii_rxd    (gmii_rxd),
    .gmii_rxdv   (gmii_rxdv),
    .gmii_rxer   (gmii_rxer),
    .sfd_pulse   (sfd_pulse),
    .ptp_valid   (ptp_valid),
    .ptp_udp     (ptp_udp),
    .ptp_event   (ptp_event),
    .ptp_msg_type(ptp_msg_type),
    .ptp_domain  (ptp_domain),
    .ptp_seq_id  (ptp_seq_id),
    .frame_error (frame_error)
  );

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  int         checks = 0;
  int         errors = 0;
  int         n_sfd, n_valid, n_err;
  logic       valid_at_gap;
  logic [7:0] frm [0:299];

  // One clock of stimulus; strobes seen after the edge are tallied.
  task automatic drive(input logic [7:0] d, input logic dv, input logic er, input logic rs);
    @(negedge gmii_rx_clk);
    gmii_rxd  = d;
    gmii_rxdv = dv;
    gmii_rxer = er;
    reset     = rs;
    @(posedge gmii_rx_clk);
    #1;
    if (sfd_pulse)   n_sfd++;
    if (ptp_valid)   n_valid++;
    if (frame_error) n_err++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    n_sfd = 0; n_valid = 0; n_err = 0; valid_at_gap = 1'b0;
  endtask

  task automatic fill_generic(input int len);
    for (int k = 0; k < len; k++) frm[k] = 8'(k) ^ 8'h3C;
  endtask

  task automatic build_l2(input logic [7:0] b14, input logic [7:0] dom, input logic [15:0] seq, input int len);
    fill_generic(len);
    frm[12] = 8'h88; frm[13] = 8'hF7; frm[14] = b14; frm[15] = 8'h02;
    frm[18] = dom;   frm[44] = seq[15:8]; frm[45] = seq[7:0];
  endtask

  task automatic build_udp(input logic [7:0] b42, input logic [7:0] dom, input logic [15:0] seq,
                           input logic [15:0] port, input int len);
    fill_generic(len);
    frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45; frm[23] = 8'h11;
    frm[36] = port[15:8]; frm[37] = port[7:0];
    frm[42] = b42; frm[43] = 8'h02; frm[46] = dom;
    frm[72] = seq[15:8]; frm[73] = seq[7:0];
  endtask

  // Preamble, SFD, frm[0..len-1], then one rxdv=0 gap cycle. er_at == len
  // puts rxer on the gap cycle. rst_at pulses reset with that byte.
  task automatic send_frame(input int len, input int er_at, input int rst_at);
    for (int k = 0; k < 7; k++) drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'hD5, 1'b1, 1'b0, 1'b0);
    checks++;
    if (sfd_pulse !== 1'b1) begin
      errors++; $display("FAIL sfd_timing got %b want 1", sfd_pulse);
    end
    for (int k = 0; k < len; k++) begin
      drive(frm[k], 1'b1, k == er_at, k == rst_at);
      if (k == rst_at) begin
        checks++;
        if ({sfd_pulse, ptp_valid, frame_error, ptp_udp, ptp_event, ptp_msg_type, ptp_domain, ptp_seq_id} !== 33'd0) begin
          errors++;
          $display("FAIL reset_mid_frame outputs got seq=%h dom=%h type=%h v=%b e=%b want all 0",
                   ptp_seq_id, ptp_domain, ptp_msg_type, ptp_valid, frame_error);
        end
      end
    end
    drive(8'h00, 1'b0, er_at == len, 1'b0);
    valid_at_gap = ptp_valid;
  endtask

  task automatic test_reset();
    clear_counts();
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (sfd_pulse !== 1'b0)    begin errors++; $display("FAIL reset_sfd got %b want 0", sfd_pulse); end
    checks++; if (ptp_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b want 0", ptp_valid); end
    checks++; if (frame_error !== 1'b0)  begin errors++; $display("FAIL reset_ferr got %b want 0", frame_error); end
    checks++; if (ptp_seq_id !== 16'h0)  begin errors++; $display("FAIL reset_seq got %h want 0", ptp_seq_id); end
    checks++; if ({ptp_udp, ptp_event, ptp_msg_type, ptp_domain} !== 14'h0) begin
      errors++; $display("FAIL reset_data got udp=%b ev=%b type=%h dom=%h want 0", ptp_udp, ptp_event, ptp_msg_type, ptp_domain);
    end
    idle(2);
  endtask

  task automatic test_l2_sync();
    clear_counts();
    build_l2(8'h00, 8'h00, 16'h1234, 64);
    send_frame(64, -1, -1);
    checks++; if (valid_at_gap !== 1'b1) begin errors++; $display("FAIL l2_valid_timing got %b want 1", valid_at_gap); end
    idle(2);
    checks++; if (n_valid !== 1)          begin errors++; $display("FAIL l2_valid_count got %0d want 1", n_valid); end
    checks++; if (n_err !== 0)            begin errors++; $display("FAIL l2_ferr got %0d want 0", n_err); end
    checks++; if (ptp_msg_type !== 4'h0)  begin errors++; $display("FAIL l2_type got %h want 0", ptp_msg_type); end
    checks++; if (ptp_event !== 1'b1)     begin errors++; $display("FAIL l2_event got %b want 1", ptp_event); end
    checks++; if (ptp_udp !== 1'b0)       begin errors++; $display("FAIL l2_udp got %b want 0", ptp_udp); end
    checks++; if (ptp_seq_id !== 16'h1234) begin errors++; $display("FAIL l2_seq got %h want 1234", ptp_seq_id); end
    checks++; if (ptp_domain !== 8'h00)   begin errors++; $display("FAIL l2_dom got %h want 00", ptp_domain); end
    $display("l2_sync: valid=%0d seq=%h", n_valid, ptp_seq_id);
  endtask

  task automatic test_udp_follow_up();
    clear_counts();
    build_udp(8'h08, 8'h05, 16'hBEEF, 16'd320, 90);
    send_frame(90, -1, -1);
    idle(2);
    checks++; if (n_valid !== 1)          begin errors++; $display("FAIL udp_valid got %0d want 1", n_valid); end
    checks++; if (n_err !== 0)            begin errors++; $display("FAIL udp_ferr got %0d want 0", n_err); end
    checks++; if (ptp_msg_type !== 4'h8)  begin errors++; $display("FAIL udp_type got %h want 8", ptp_msg_type); end
    checks++; if (ptp_event !== 1'b0)     begin errors++; $display("FAIL udp_event got %b want 0", ptp_event); end
    checks++; if (ptp_udp !== 1'b1)       begin errors++; $display("FAIL udp_udp got %b want 1", ptp_udp); end
    checks++; if (ptp_domain !== 8'h05)   begin errors++; $display("FAIL udp_dom got %h want 05", ptp_domain); end
    checks++; if (ptp_seq_id !== 16'hBEEF) begin errors++; $display("FAIL udp_seq got %h want beef", ptp_seq_id); end
    $display("udp_follow_up: valid=%0d seq=%h", n_valid, ptp_seq_id);
  endtask

  task automatic test_udp_bad_port();
    clear_counts();
    build_udp(8'h08, 8'h05, 16'h4321, 16'd1234, 90);
    send_frame(90, -1, -1);
    idle(2);
    checks++; if (n_sfd !== 1)            begin errors++; $display("FAIL badport_sfd got %0d want 1", n_sfd); end
    checks++; if (n_valid !== 0)          begin errors++; $display("FAIL badport_valid got %0d want 0", n_valid); end
    checks++; if (n_err !== 0)            begin errors++; $display("FAIL badport_ferr got %0d want 0", n_err); end
    checks++; if (ptp_seq_id !== 16'hBEEF) begin errors++; $display("FAIL badport_hold got %h want beef", ptp_seq_id); end
    $display("udp_bad_port: sfd=%0d valid=%0d err=%0d", n_sfd, n_valid, n_err);
  endtask

  task automatic test_rxer_then_good();
    clear_counts();
    build_l2(8'h00, 8'h00, 16'h5555, 64);
    send_frame(64, 30, -1);
    checks++; if (n_err !== 1)            begin errors++; $display("FAIL rxer_ferr got %0d want 1", n_err); end
    checks++; if (n_valid !== 0)          begin errors++; $display("FAIL rxer_valid got %0d want 0", n_valid); end
    // Back-to-back: the gap inside send_frame is the only idle cycle.
    clear_counts();
    build_l2(8'h01, 8'h07, 16'h0042, 60);
    send_frame(60, -1, -1);
    idle(1);
    checks++; if (n_valid !== 1)          begin errors++; $display("FAIL b2b_valid got %0d want 1", n_valid); end
    checks++; if (ptp_seq_id !== 16'h0042) begin errors++; $display("FAIL b2b_seq got %h want 0042", ptp_seq_id); end
    checks++; if ({ptp_msg_type, ptp_domain, ptp_udp, ptp_event} !== {4'h1, 8'h07, 1'b0, 1'b1}) begin
      errors++; $display("FAIL b2b_fields got type=%h dom=%h udp=%b ev=%b want 1 07 0 1", ptp_msg_type, ptp_domain, ptp_udp, ptp_event);
    end
    $display("rxer_then_good: valid=%0d seq=%h", n_valid, ptp_seq_id);
  endtask

  task automatic test_truncated();
    clear_counts();
    build_l2(8'h00, 8'h00, 16'h9999, 41);
    send_frame(41, -1, -1);
    idle(1);
    checks++; if (n_err !== 1)            begin errors++; $display("FAIL trunc_ferr got %0d want 1", n_err); end
    checks++; if (n_valid !== 0)          begin errors++; $display("FAIL trunc_valid got %0d want 0", n_valid); end
    $display("truncated: err=%0d valid=%0d", n_err, n_valid);
  endtask

  task automatic test_bad_preamble();
    clear_counts();
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'h12, 1'b1, 1'b0, 1'b0);
    checks++; if (frame_error !== 1'b1)   begin errors++; $display("FAIL badpre_ferr got %b want 1", frame_error); end
    // A late preamble/SFD while dropping must not start a frame.
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) drive(8'h88, 1'b1, 1'b0, 1'b0);
    idle(2);
    checks++; if ({n_sfd, n_valid, n_err} !== {32'd0, 32'd0, 32'd1}) begin
      errors++; $display("FAIL badpre_drop got sfd=%0d valid=%0d err=%0d want 0 0 1", n_sfd, n_valid, n_err);
    end
    $display("bad_preamble: sfd=%0d err=%0d", n_sfd, n_err);
  endtask

  task automatic test_vlan();
    clear_counts();
    build_l2(8'h00, 8'h00, 16'h1111, 68);
    frm[12] = 8'h81; frm[13] = 8'h00;
    send_frame(68, -1, -1);
    idle(1);
    checks++; if ({n_valid, n_err} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL vlan got valid=%0d err=%0d want 0 0", n_valid, n_err);
    end
    $display("vlan: valid=%0d err=%0d", n_valid, n_err);
  endtask

  task automatic test_rxer_at_end();
    clear_counts();
    build_l2(8'h00, 8'h00, 16'h2222, 64);
    send_frame(64, 64, -1);
    idle(1);
    checks++; if ({n_valid, n_err} !== {32'd0, 32'd1}) begin
      errors++; $display("FAIL rxer_end got valid=%0d err=%0d want 0 1", n_valid, n_err);
    end
    $display("rxer_at_end: valid=%0d err=%0d", n_valid, n_err);
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    build_udp(8'h00, 8'h09, 16'hCAFE, 16'd319, 90);
    send_frame(90, -1, 20);
    checks++; if ({n_valid, n_err} !== {32'd0, 32'd0}) begin
      errors++; $display("FAIL rst_rest got valid=%0d err=%0d want 0 0", n_valid, n_err);
    end
    checks++; if (ptp_seq_id !== 16'h0)   begin errors++; $display("FAIL rst_hold got %h want 0", ptp_seq_id); end
    clear_counts();
    build_udp(8'h00, 8'h2A, 16'h0BAD, 16'd319, 80);
    send_frame(80, -1, -1);
    idle(1);
    checks++; if (n_valid !== 1)          begin errors++; $display("FAIL rst_next_valid got %0d want 1", n_valid); end
    checks++; if (ptp_seq_id !== 16'h0BAD) begin errors++; $display("FAIL rst_next_seq got %h want 0bad", ptp_seq_id); end
    checks++; if ({ptp_udp, ptp_event, ptp_domain} !== {1'b1, 1'b1, 8'h2A}) begin
      errors++; $display("FAIL rst_next_fields got udp=%b ev=%b dom=%h want 1 1 2a", ptp_udp, ptp_event, ptp_domain);
    end
    $display("reset_mid_frame: valid=%0d seq=%h", n_valid, ptp_seq_id);
  endtask

  task automatic test_long_frame();
    clear_counts();
    build_l2(8'h00, 8'h03, 16'h7777, 300);
    send_frame(300, -1, -1);
    idle(1);
    checks++; if (n_valid !== 1)          begin errors++; $display("FAIL long_valid got %0d want 1", n_valid); end
    checks++; if (ptp_seq_id !== 16'h7777) begin errors++; $display("FAIL long_seq got %h want 7777", ptp_seq_id); end
    $display("long_frame: valid=%0d seq=%h", n_valid, ptp_seq_id);
  endtask

  initial begin
    test_reset();
    test_l2_sync();
    test_udp_follow_up();
    test_udp_bad_port();
    test_rxer_then_good();
    test_truncated();
    test_bad_preamble();
    test_vlan();
    test_rxer_at_end();
    test_reset_mid_frame();
    test_long_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
